// File: rtl/op_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : op_mem_pkg
//  Description : Shared definitions for the output-peripheral buffer.
//                Word index map, load size and LCD sequencer state encodings,
//                and a byte-lane merge helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package op_mem_pkg;

   // Word indices inside the peripheral window
   localparam int IDX_LEDR   = 0;
   localparam int IDX_LEDG   = 4;
   localparam int IDX_HEX_LO = 8;
   localparam int IDX_HEX_HI = 9;
   localparam int IDX_LCD    = 12;
   localparam int IDX_STAT   = 13;

   typedef enum logic [1:0] {
      LD_BYTE = 2'b00,
      LD_HALF = 2'b01,
      LD_WORD = 2'b10,
      LD_RSVD = 2'b11
   } ld_size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      PULSE = 2'd2,
      HOLD  = 2'd3
   } lcd_state_e;

   // Replace the lanes of old_w selected by mask with the lanes of new_w
   function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/op_lcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : op_lcd_seq
//  Description : LCD enable strobe sequencer. An accepted store starts an
//                IDLE->SETUP->PULSE->HOLD->IDLE walk; o_lcd_en is high only in
//                PULSE. Stores arriving while not IDLE set the overrun flag.
//  Ports       : i_clk, i_rst      clock / async active-high reset
//                i_st_req          LCD register store request
//                i_clr             overrun clear request
//                o_accept          store request accepted (FSM was IDLE)
//                o_busy            FSM not IDLE
//                o_overrun         sticky dropped-store flag
//                o_lcd_en          LCD enable strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module op_lcd_seq
   import op_mem_pkg::*;
#(
   parameter int LCD_SETUP_CYC = 2,
   parameter int LCD_PULSE_CYC = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_st_req,
   input  logic i_clr,
   output logic o_accept,
   output logic o_busy,
   output logic o_overrun,
   output logic o_lcd_en
);

   localparam int CNT_MAX = (LCD_SETUP_CYC > LCD_PULSE_CYC) ? LCD_SETUP_CYC : LCD_PULSE_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   // Counter is loaded with N-1 on entry so the state lasts exactly N cycles
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(LCD_SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(LCD_PULSE_CYC - 1);

   lcd_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovr_q, ovr_d;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ovr_d    = ovr_q;
      o_accept = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_st_req) begin
               o_accept = 1'b1;
               state_d  = SETUP;
               cnt_d    = SETUP_LD;
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               state_d = PULSE;
               cnt_d   = PULSE_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         PULSE: begin
            if (cnt_q == '0) begin
               state_d = HOLD;
               cnt_d   = SETUP_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin // HOLD
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      endcase

      // Clear and LCD store target different words, so they never coincide
      if (i_clr) ovr_d = 1'b0;
      if (i_st_req && (state_q != IDLE)) ovr_d = 1'b1;
   end

   assign o_busy    = (state_q != IDLE);
   assign o_overrun = ovr_q;
   assign o_lcd_en  = (state_q == PULSE);

endmodule
`default_nettype wire

// File: rtl/op_mem_v3.sv
`default_nettype none
// ============================================================================
//  Module      : op_mem_v3
//  Description : Output-peripheral buffer for the LSU. Byte-masked word array,
//                registered sub-word loads with sign/zero extension, status
//                word and LCD register driven through op_lcd_seq.
//  Ports       : i_clk, i_rst                 clock / async active-high reset
//                i_lsu_addr/wren/bmask        store address, request, lanes
//                i_st_data                    lane-aligned store data
//                i_lsu_rden/i_ld_size/i_ld_uns load request, size, unsigned
//                o_ld_data/o_ld_valid/o_misalign registered load result
//                o_io_ledr/ledg/hex0..7/lcd   board pin outputs
//                o_lcd_en                     LCD enable strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module op_mem_v3
   import op_mem_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR     = 16'h7000,
   parameter int          DEPTH_LOG2    = 5,
   parameter int          LCD_SETUP_CYC = 2,
   parameter int          LCD_PULSE_CYC = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_lsu_addr,
   input  logic        i_lsu_wren,
   input  logic [3:0]  i_lsu_bmask,
   input  logic [31:0] i_st_data,
   input  logic        i_lsu_rden,
   input  logic [1:0]  i_ld_size,
   input  logic        i_ld_uns,
   output logic [31:0] o_ld_data,
   output logic        o_ld_valid,
   output logic        o_misalign,
   output logic [31:0] o_io_ledr,
   output logic [31:0] o_io_ledg,
   output logic [6:0]  o_io_hex0,
   output logic [6:0]  o_io_hex1,
   output logic [6:0]  o_io_hex2,
   output logic [6:0]  o_io_hex3,
   output logic [6:0]  o_io_hex4,
   output logic [6:0]  o_io_hex5,
   output logic [6:0]  o_io_hex6,
   output logic [6:0]  o_io_hex7,
   output logic [31:0] o_io_lcd,
   output logic        o_lcd_en
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int IW    = DEPTH_LOG2;

   logic [31:0]   mem_q [DEPTH];
   logic [31:0]   lcd_q;
   logic [31:0]   ld_data_q, ld_data_d;
   logic          ld_valid_q, misalign_q, misalign_d;
   logic          hit, st_hit, st_lcd, st_stat, st_arr, clr_req;
   logic          lcd_accept, lcd_busy, lcd_overrun;
   logic [IW-1:0] idx;
   logic [31:0]   rd_word;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic          unused_addr_hi;

   // Upper address half is decoded by the LSU mux, not here
   assign unused_addr_hi = ^i_lsu_addr[31:16];

   assign hit     = (i_lsu_addr[15:IW+2] == BASE_ADDR[15:IW+2]);
   assign idx     = i_lsu_addr[IW+1:2];
   assign st_hit  = i_lsu_wren & hit & (|i_lsu_bmask);
   assign st_lcd  = st_hit & (idx == IW'(IDX_LCD));
   assign st_stat = st_hit & (idx == IW'(IDX_STAT));
   assign st_arr  = st_hit & ~st_lcd & ~st_stat;
   assign clr_req = st_stat & i_lsu_bmask[0] & i_st_data[1];

   op_lcd_seq #(
      .LCD_SETUP_CYC (LCD_SETUP_CYC),
      .LCD_PULSE_CYC (LCD_PULSE_CYC)
   ) u_lcd_seq (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_st_req  (st_lcd),
      .i_clr     (clr_req),
      .o_accept  (lcd_accept),
      .o_busy    (lcd_busy),
      .o_overrun (lcd_overrun),
      .o_lcd_en  (o_lcd_en)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int w = 0; w < DEPTH; w++) mem_q[w] <= '0;
      end else if (st_arr) begin
         mem_q[idx] <= byte_merge(mem_q[idx], i_st_data, i_lsu_bmask);
      end
   end

   // Load path reads the pre-edge contents, giving read-before-write
   always_comb begin
      rd_word    = '0;
      ld_byte    = '0;
      ld_half    = '0;
      misalign_d = 1'b0;
      ld_data_d  = '0;
      if (hit) begin
         if (idx == IW'(IDX_LCD))       rd_word = lcd_q;
         else if (idx == IW'(IDX_STAT)) rd_word = {30'b0, lcd_overrun, lcd_busy};
         else                           rd_word = mem_q[idx];
      end
      case (ld_size_e'(i_ld_size))
         LD_BYTE: begin
            ld_byte   = rd_word[{i_lsu_addr[1:0], 3'b000} +: 8];
            ld_data_d = {{24{~i_ld_uns & ld_byte[7]}}, ld_byte};
         end
         LD_HALF: begin
            misalign_d = i_lsu_addr[0];
            ld_half    = i_lsu_addr[1] ? rd_word[31:16] : rd_word[15:0];
            ld_data_d  = {{16{~i_ld_uns & ld_half[15]}}, ld_half};
         end
         default: begin
            misalign_d = |i_lsu_addr[1:0];
            ld_data_d  = rd_word;
         end
      endcase
      if (misalign_d) ld_data_d = '0;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ld_data_q  <= '0;
         ld_valid_q <= 1'b0;
         misalign_q <= 1'b0;
         lcd_q      <= '0;
      end else begin
         ld_valid_q <= i_lsu_rden;
         misalign_q <= i_lsu_rden & misalign_d;
         if (i_lsu_rden) ld_data_q <= ld_data_d;
         if (lcd_accept) lcd_q <= byte_merge(lcd_q, i_st_data, i_lsu_bmask);
      end
   end

   assign o_ld_data  = ld_data_q;
   assign o_ld_valid = ld_valid_q;
   assign o_misalign = misalign_q;
   assign o_io_ledr  = mem_q[IDX_LEDR];
   assign o_io_ledg  = mem_q[IDX_LEDG];
   assign o_io_hex0  = mem_q[IDX_HEX_LO][6:0];
   assign o_io_hex1  = mem_q[IDX_HEX_LO][14:8];
   assign o_io_hex2  = mem_q[IDX_HEX_LO][22:16];
   assign o_io_hex3  = mem_q[IDX_HEX_LO][30:24];
   assign o_io_hex4  = mem_q[IDX_HEX_HI][6:0];
   assign o_io_hex5  = mem_q[IDX_HEX_HI][14:8];
   assign o_io_hex6  = mem_q[IDX_HEX_HI][22:16];
   assign o_io_hex7  = mem_q[IDX_HEX_HI][30:24];
   assign o_io_lcd   = lcd_q;

endmodule
`default_nettype wire

// File: tb/tb_op_mem_v3.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_op_mem_v3
//  Description : Self-checking bench for op_mem_v3: directed scenarios plus a
//                randomized load/store run against a word-array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_op_mem_v3;

   localparam int          S    = 2;
   localparam int          P    = 4;
   localparam logic [15:0] BASE = 16'h7000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic        wren;
   logic [3:0]  bmask;
   logic [31:0] sdata;
   logic        rden;
   logic [1:0]  size;
   logic        uns;
   logic [31:0] ld_data, ledr, ledg, io_lcd;
   logic        ld_valid, misalign, lcd_en;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] mdl [32];

   always #5 clk = ~clk;

   op_mem_v3 #(
      .BASE_ADDR(BASE), .DEPTH_LOG2(5), .LCD_SETUP_CYC(S), .LCD_PULSE_CYC(P)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_lsu_addr(addr), .i_lsu_wren(wren),
      .i_lsu_bmask(bmask), .i_st_data(sdata), .i_lsu_rden(rden),
      .i_ld_size(size), .i_ld_uns(uns), .o_ld_data(ld_data),
      .o_ld_valid(ld_valid), .o_misalign(misalign), .o_io_ledr(ledr),
      .o_io_ledg(ledg), .o_io_hex0(hex0), .o_io_hex1(hex1), .o_io_hex2(hex2),
      .o_io_hex3(hex3), .o_io_hex4(hex4), .o_io_hex5(hex5), .o_io_hex6(hex6),
      .o_io_hex7(hex7), .o_io_lcd(io_lcd), .o_lcd_en(lcd_en)
   );

   // ---------------- reference model ----------------
   function automatic logic mdl_hit(input logic [31:0] a);
      return a[15:7] == BASE[15:7];
   endfunction

   task automatic mdl_clear();
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
   endtask

   task automatic mdl_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      int w;
      w = int'(a[6:2]);
      if (mdl_hit(a) && w != 12 && w != 13) begin
         for (int b = 0; b < 4; b++)
            if (m[b]) mdl[w] = (mdl[w] & ~(32'hFF << (8*b))) | (d & (32'hFF << (8*b)));
      end
   endtask

   task automatic mdl_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                           output logic [31:0] v, output logic mis);
      logic [31:0] w;
      int lane;
      w    = mdl_hit(a) ? mdl[int'(a[6:2])] : 32'h0;
      lane = int'(a[1:0]);
      mis  = 1'b0;
      if (sz == 2'b00) begin
         v = (w >> (8*lane)) & 32'hFF;
         if (!u && v >= 32'h80) v = v - 32'h100;
      end else if (sz == 2'b01) begin
         mis = (lane % 2) != 0;
         v   = (w >> (16*(lane/2))) & 32'hFFFF;
         if (!u && v >= 32'h8000) v = v - 32'h10000;
      end else begin
         mis = lane != 0;
         v   = w;
      end
      if (mis) v = 32'h0;
   endtask

   // ---------------- drivers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      wren = 1'b0; rden = 1'b0; bmask = 4'h0; sdata = 32'h0;
      size = 2'b10; uns = 1'b0; addr = 32'h0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      addr = a; sdata = d; bmask = m; wren = 1'b1;
      mdl_store(a, d, m);
      cyc();
      wren = 1'b0;
   endtask

   task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic u);
      addr = a; size = sz; uns = u; rden = 1'b1;
      cyc();
      rden = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_in();
      rst = 1'b1;
      mdl_clear();
      repeat (2) cyc();
      total++; if (ledr !== 32'h0 || ledg !== 32'h0 || io_lcd !== 32'h0) begin bad++; $display("FAIL reset_words: ledr=%h ledg=%h lcd=%h required 0", ledr, ledg, io_lcd); end
      total++; if ({hex0, hex4} !== 14'h0 || lcd_en !== 1'b0) begin bad++; $display("FAIL reset_hex_en: hex0=%h hex4=%h en=%b required 0", hex0, hex4, lcd_en); end
      total++; if (ld_data !== 32'h0 || ld_valid !== 1'b0 || misalign !== 1'b0) begin bad++; $display("FAIL reset_load: data=%h v=%b m=%b required 0", ld_data, ld_valid, misalign); end
      rst = 1'b0;
      cyc();
      load(32'h7034, 2'b10, 1'b0);
      total++; if (ld_valid !== 1'b1 || ld_data !== 32'h0) begin bad++; $display("FAIL reset_status: v=%b data=%h required 1/0", ld_valid, ld_data); end
   endtask

   task automatic test_ledr();
      store(32'h7000, 32'hDEADBEEF, 4'b1111);
      total++; if (ledr !== 32'hDEADBEEF) begin bad++; $display("FAIL ledr_word: got %h required DEADBEEF", ledr); end
      store(32'h7000, 32'h00005500, 4'b0010);
      total++; if (ledr !== 32'hDEAD55EF) begin bad++; $display("FAIL ledr_lane1: got %h required DEAD55EF", ledr); end
      store(32'h7000, 32'hFFFFFFFF, 4'b0000);
      total++; if (ledr !== 32'hDEAD55EF) begin bad++; $display("FAIL ledr_mask0: got %h required DEAD55EF", ledr); end
      store(32'h7080, 32'h12345678, 4'b1111);
      total++; if (ledr !== 32'hDEAD55EF) begin bad++; $display("FAIL ledr_miss: got %h required DEAD55EF", ledr); end
   endtask

   task automatic test_hex();
      store(32'h7020, 32'h0F7F3F06, 4'b1111);
      total++; if ({hex3, hex2, hex1, hex0} !== {7'h0F, 7'h7F, 7'h3F, 7'h06}) begin bad++; $display("FAIL hex_lo: got %h %h %h %h required 0F 7F 3F 06", hex3, hex2, hex1, hex0); end
      total++; if ({hex7, hex6, hex5, hex4} !== 28'h0) begin bad++; $display("FAIL hex_hi: got %h %h %h %h required 0", hex7, hex6, hex5, hex4); end
   endtask

   task automatic test_subword();
      store(32'h7010, 32'h000080F0, 4'b1111);
      total++; if (ledg !== 32'h000080F0) begin bad++; $display("FAIL ledg: got %h required 000080F0", ledg); end
      load(32'h7010, 2'b00, 1'b0);
      total++; if (ld_valid !== 1'b1 || ld_data !== 32'hFFFFFFF0) begin bad++; $display("FAIL byte_signed: v=%b got %h required FFFFFFF0", ld_valid, ld_data); end
      load(32'h7010, 2'b00, 1'b1);
      total++; if (ld_data !== 32'h000000F0) begin bad++; $display("FAIL byte_unsigned: got %h required 000000F0", ld_data); end
      load(32'h7010, 2'b01, 1'b0);
      total++; if (ld_data !== 32'hFFFF80F0 || misalign !== 1'b0) begin bad++; $display("FAIL half_signed: got %h m=%b required FFFF80F0 m=0", ld_data, misalign); end
      load(32'h7011, 2'b01, 1'b0);
      total++; if (misalign !== 1'b1 || ld_valid !== 1'b1 || ld_data !== 32'h0) begin bad++; $display("FAIL half_misalign: m=%b v=%b data=%h required 1 1 0", misalign, ld_valid, ld_data); end
      cyc();
      total++; if (misalign !== 1'b0 || ld_valid !== 1'b0) begin bad++; $display("FAIL pulse_width: m=%b v=%b required 0 0", misalign, ld_valid); end
      load(32'h7011, 2'b00, 1'b1);
      total++; if (ld_data !== 32'h00000080) begin bad++; $display("FAIL byte_lane1: got %h required 00000080", ld_data); end
      cyc();
      total++; if (ld_data !== 32'h00000080) begin bad++; $display("FAIL data_hold: got %h required 00000080", ld_data); end
      load(32'h6010, 2'b10, 1'b0);
      total++; if (ld_valid !== 1'b1 || ld_data !== 32'h0) begin bad++; $display("FAIL load_miss: v=%b data=%h required 1 0", ld_valid, ld_data); end
   endtask

   // Store LCD in cycle 0; cycles k>=1 follow. Enable window and status
   // timing are derived from the setup/pulse durations.
   task automatic test_lcd();
      store(32'h7030, 32'h00000041, 4'b1111);
      for (int k = 1; k <= 10; k++) begin
         total++; if (lcd_en !== (k > S && k <= S + P)) begin bad++; $display("FAIL lcd_en_c%0d: got %b required %b", k, lcd_en, (k > S && k <= S + P)); end
         if (k == 4)  begin total++; if (ld_data !== 32'h3) begin bad++; $display("FAIL lcd_status_ovr: got %h required 3", ld_data); end end
         if (k == 6)  begin total++; if (ld_data !== 32'h1) begin bad++; $display("FAIL lcd_status_clr: got %h required 1", ld_data); end end
         if (k == 7)  begin total++; if (ld_data !== 32'h41) begin bad++; $display("FAIL lcd_readback: got %h required 41", ld_data); end end
         if (k == 10) begin total++; if (ld_data !== 32'h0) begin bad++; $display("FAIL lcd_status_idle: got %h required 0", ld_data); end end
         wren = 1'b0; rden = 1'b0; size = 2'b10; uns = 1'b0;
         case (k)
            2: begin addr = 32'h7030; sdata = 32'h000000AA; bmask = 4'b1111; wren = 1'b1; end
            3, 5, 9: begin addr = 32'h7034; rden = 1'b1; end
            4: begin addr = 32'h7034; sdata = 32'h2; bmask = 4'b0001; wren = 1'b1; end
            6: begin addr = 32'h7030; rden = 1'b1; end
            default: ;
         endcase
         cyc();
      end
      total++; if (io_lcd !== 32'h41) begin bad++; $display("FAIL lcd_drop: got %h required 41", io_lcd); end
   endtask

   task automatic test_reset_mid_pulse();
      store(32'h7030, 32'h00000099, 4'b1111);
      repeat (S + 1) cyc();
      total++; if (lcd_en !== 1'b1) begin bad++; $display("FAIL pre_reset_en: got %b required 1", lcd_en); end
      #2 rst = 1'b1;
      mdl_clear();
      #1;
      total++; if (lcd_en !== 1'b0 || io_lcd !== 32'h0 || ledr !== 32'h0 || ledg !== 32'h0) begin bad++; $display("FAIL async_reset: en=%b lcd=%h ledr=%h ledg=%h required 0", lcd_en, io_lcd, ledr, ledg); end
      total++; if (ld_data !== 32'h0 || ld_valid !== 1'b0 || {hex3, hex0} !== 14'h0) begin bad++; $display("FAIL async_reset_ld: data=%h v=%b hex=%h required 0", ld_data, ld_valid, {hex3, hex0}); end
      cyc();
      rst = 1'b0;
      cyc();
      total++; if (lcd_en !== 1'b0) begin bad++; $display("FAIL release_glitch: got %b required 0", lcd_en); end
      store(32'h7030, 32'h00000077, 4'b0001);
      for (int k = 1; k <= 10; k++) begin
         total++; if (lcd_en !== (k > S && k <= S + P)) begin bad++; $display("FAIL relcd_en_c%0d: got %b required %b", k, lcd_en, (k > S && k <= S + P)); end
         if (k == 10) begin total++; if (ld_data !== 32'h2) begin bad++; $display("FAIL hold_expiry_ovr: got %h required 2", ld_data); end end
         wren = 1'b0; rden = 1'b0; size = 2'b10;
         if (k == 2*S + P) begin addr = 32'h7030; sdata = 32'h12; bmask = 4'b1111; wren = 1'b1; end
         if (k == 2*S + P + 1) begin addr = 32'h7034; rden = 1'b1; end
         cyc();
      end
      total++; if (io_lcd !== 32'h77) begin bad++; $display("FAIL relcd_data: got %h required 77", io_lcd); end
      store(32'h7034, 32'h2, 4'b0001);
      load(32'h7034, 2'b10, 1'b0);
      total++; if (ld_data !== 32'h0) begin bad++; $display("FAIL ovr_clear: got %h required 0", ld_data); end
   endtask

   task automatic test_back_to_back();
      store(32'h7004, 32'h9, 4'b1111);
      addr = 32'h7004; sdata = 32'h1; bmask = 4'b1111; wren = 1'b1;
      size = 2'b10; uns = 1'b0; rden = 1'b1;
      mdl_store(32'h7004, 32'h1, 4'b1111);
      cyc();
      wren = 1'b0; rden = 1'b0;
      total++; if (ld_data !== 32'h9) begin bad++; $display("FAIL rbw_old: got %h required 9", ld_data); end
      load(32'h7004, 2'b10, 1'b0);
      total++; if (ld_data !== 32'h1) begin bad++; $display("FAIL rbw_new: got %h required 1", ld_data); end
   endtask

   task automatic test_random();
      logic [31:0] ev, hold, a;
      logic        em, did_rd;
      int          w;
      hold = ld_data;
      for (int n = 0; n < 400; n++) begin
         w = int'($urandom_range(0, 31));
         if (w == 12 || w == 13) w = 1;
         a = {$urandom_range(0, 65535), 16'h0};
         if ($urandom_range(0, 7) == 0) a[15:0] = 16'h7080 + 16'($urandom_range(0, 127));
         else                           a[15:0] = BASE + 16'(w * 4) + 16'($urandom_range(0, 3));
         addr   = a;
         wren   = $urandom_range(0, 1) == 1;
         rden   = $urandom_range(0, 1) == 1;
         bmask  = 4'($urandom_range(0, 15));
         sdata  = $urandom;
         size   = 2'($urandom_range(0, 3));
         uns    = $urandom_range(0, 1) == 1;
         did_rd = rden;
         ev     = 32'h0;
         em     = 1'b0;
         if (rden) mdl_load(a, size, uns, ev, em);
         if (wren) mdl_store(a, sdata, bmask);
         cyc();
         if (did_rd) begin
            hold = ev;
            total++; if (ld_valid !== 1'b1 || ld_data !== ev || misalign !== em) begin bad++; $display("FAIL rnd_load_%0d: a=%h sz=%0d got v=%b d=%h m=%b required v=1 d=%h m=%b", n, a, size, ld_valid, ld_data, misalign, ev, em); end
         end else begin
            total++; if (ld_valid !== 1'b0 || ld_data !== hold) begin bad++; $display("FAIL rnd_idle_%0d: got v=%b d=%h required v=0 d=%h", n, ld_valid, ld_data, hold); end
         end
         total++; if (ledr !== mdl[0] || ledg !== mdl[4] || hex2 !== mdl[8][22:16] || hex7 !== mdl[9][30:24]) begin bad++; $display("FAIL rnd_pins_%0d: ledr=%h ledg=%h required %h %h", n, ledr, ledg, mdl[0], mdl[4]); end
      end
      wren = 1'b0; rden = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (i == 12 || i == 13) continue;
         load(32'h7000 + 32'(i * 4), 2'b10, 1'b0);
         total++; if (ld_data !== mdl[i]) begin bad++; $display("FAIL rnd_final_w%0d: got %h required %h", i, ld_data, mdl[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_ledr();
      test_hex();
      test_subword();
      test_lcd();
      test_reset_mid_pulse();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
